accumulator_buffer: RTL
=======================

Name: accumulator_buffer

Overview:
- Sits directly downstream of the column-alignment stage.
- Captures each aligned two-column result row into a double-banked row buffer, either overwriting or accumulating partial sums across K-tiles.
- On command, swaps banks and drains the completed bank to the activation/output stage over a valid/ready stream.
- Decouples systolic-array write bursts from downstream back-pressure.

Parameters:
- DEPTH, 8, rows per bank (power of two, ≥2)
- DATA_W, 16, signed width of incoming column values
- ACC_W, 32, signed width of stored accumulators (ACC_W > DATA_W)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- clear  in  1  start new inference: empty write bank (sync, 1-cycle pulse)
- in_valid  in  1  aligned row present
- in_col0  in  DATA_W  signed column-0 result
- in_col1  in  DATA_W  signed column-1 result
- acc_mode  in  1  0 = overwrite row, 1 = add to stored row
- rewind  in  1  return write pointer to row 0, keep stored rows (next K-tile)
- swap  in  1  hand write bank to drain side
- swap_ready  out  1  drain side idle; swap will be accepted
- out_valid  out  1  drained row valid
- out_ready  in  1  downstream accepts row
- out_col0  out  ACC_W  accumulated column 0
- out_col1  out  ACC_W  accumulated column 1
- out_last  out  1  final row of drained bank
- overflow  out  1  sticky: write attempted with bank full

Behaviour:
- Reset (reset=0, async): wr_ptr=0, rows_valid=0, wr_bank=0, drain FSM IDLE, out_valid=0, out_col0/out_col1=0, out_last=0, overflow=0, swap_ready=1. Memory contents undefined; never read before being written.
- Write path: on in_valid with wr_ptr<DEPTH, row wr_ptr of the write bank is updated at the next edge, then wr_ptr increments.
  - Write value: if acc_mode=1 and wr_ptr<rows_valid, stored+sext(in); otherwise sext(in).
  - Each column saturates independently to the signed ACC_W range (max 2^(ACC_W-1)-1, min -2^(ACC_W-1)).
  - rows_valid = max(rows_valid, wr_ptr+1).
- Full: in_valid with wr_ptr==DEPTH drops the row and sets overflow. No wrap-around.
- rewind: wr_ptr<=0; rows_valid and contents are kept.
  - rewind with in_valid in the same cycle: the write uses the old wr_ptr, then wr_ptr<=0.
- clear: wr_ptr<=0, rows_valid<=0, overflow<=0. The drain side is unaffected.
  - clear wins over in_valid, rewind and swap in the same cycle; those inputs are ignored.
- swap is accepted only when swap_ready=1; while swap_ready=0 it is ignored (no queuing).
  - On acceptance: wr_bank toggles, drain_count<=rows_valid (including any same-cycle write), wr_ptr<=0, rows_valid<=0.
  - The drain FSM enters DRAIN, or stays IDLE if the count is 0.
- Drain FSM:
  - IDLE: swap_ready=1, out_valid=0.
  - DRAIN: swap_ready=0.
    - The cycle after swap, out_valid=1 with row 0 of the read bank (registered outputs, 1-cycle latency).
    - Data holds stable while out_ready=0.
    - On out_valid&&out_ready, rd_ptr increments and the next row is presented in the following cycle (full throughput, one row/cycle when ready stays high).
    - out_last=1 on row drain_count-1. The accepting handshake on that row returns the FSM to IDLE, with out_valid=0 next cycle.
- Reset mid-drain aborts the drain; all outputs return to reset values immediately.
- Writes into the write bank proceed concurrently with the drain; banks are never shared.

Test Plan:
- Overwrite:
  - Stimulus: 3 rows (1,2), (-3,4), (5,-6), acc_mode=0, swap, out_ready=1.
  - Required: out_valid for 3 consecutive cycles starting 1 cycle after swap, same values sign-extended, out_last on the third row.
- Accumulate:
  - Stimulus: 2 rows (10,20),(30,40); rewind; 2 rows (1,2),(3,4) acc_mode=1; swap.
  - Required: drain (11,22),(33,44).
- Saturation:
  - Stimulus: ACC_W=17, rows (32767,-32768) repeated 4 times with acc_mode=1 and rewind between them.
  - Required: drain (65535,-65536).
- Full/overflow:
  - Stimulus: DEPTH+1 rows written.
  - Required: overflow=1, DEPTH rows drained, the extra row is absent; clear drops overflow to 0.
- Back-pressure and swap-while-busy:
  - Stimulus: toggle out_ready 1,0,0,1 during the drain; pulse swap mid-drain.
  - Required: data held stable while out_ready=0; swap ignored; swap_ready=1 only after the out_last handshake.
- Async reset mid-drain:
  - Stimulus: drop reset between clock edges during DRAIN.
  - Required: out_valid and out_last go to 0 immediately, swap_ready=1 after release.

Source files
------------

// File: rtl/accumulator_buffer.sv
// accumulator_buffer: double-banked two-column row buffer with overwrite/accumulate writes
// and a valid/ready drain of the completed bank.
module accumulator_buffer #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 16,
  parameter int ACC_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_col0,
  input  logic [DATA_W-1:0] in_col1,
  input  logic              acc_mode,
  input  logic              rewind,
  input  logic              swap,
  output logic              swap_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_col0,
  output logic [ACC_W-1:0]  out_col1,
  output logic              out_last,
  output logic              overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] FULL = PW'(DEPTH);
  typedef enum logic {IDLE, DRAIN} state_t;
  state_t state, state_next;
  logic [PW-1:0] wr_ptr, rows_valid, rows_next, drain_count, rd_ptr, cnt, load_idx;
  logic wr_bank, w_en, swap_acc, acc, load, fwd;
  logic [AW:0] w_addr, r_addr;
  logic [ACC_W-1:0] mem0 [2*DEPTH];
  logic [ACC_W-1:0] mem1 [2*DEPTH];
  logic [ACC_W-1:0] w0, w1;
  function automatic logic [ACC_W-1:0] sat(input logic [ACC_W:0] s);
    return s[ACC_W] != s[ACC_W-1] ? {s[ACC_W], {(ACC_W-1){~s[ACC_W]}}} : s[ACC_W-1:0];
  endfunction
  assign w_addr = {wr_bank, wr_ptr[AW-1:0]};
  assign w_en = in_valid && !clear && wr_ptr != FULL;
  assign swap_acc = swap && !clear && state == IDLE;
  assign acc = acc_mode && wr_ptr < rows_valid;
  assign w0 = sat((acc ? {mem0[w_addr][ACC_W-1], mem0[w_addr]} : '0)
                  + {{(ACC_W+1-DATA_W){in_col0[DATA_W-1]}}, in_col0});
  assign w1 = sat((acc ? {mem1[w_addr][ACC_W-1], mem1[w_addr]} : '0)
                  + {{(ACC_W+1-DATA_W){in_col1[DATA_W-1]}}, in_col1});
  assign rows_next = w_en && wr_ptr >= rows_valid ? wr_ptr + 1'b1 : rows_valid;
  assign cnt = swap_acc ? rows_next : drain_count;
  assign swap_ready = state == IDLE;
  assign out_valid = state == DRAIN;
  always_comb begin
    state_next = state;
    load = 1'b0;
    load_idx = state == IDLE ? '0 : rd_ptr + 1'b1;
    if (state == IDLE) begin
      state_next = swap_acc && rows_next != '0 ? DRAIN : IDLE;
      load = swap_acc && rows_next != '0;
    end else if (out_ready) begin
      state_next = out_last ? IDLE : DRAIN;
      load = !out_last;
    end
  end
  // At swap the bank being handed over is still wr_bank; a same-cycle write to row 0 is forwarded.
  assign r_addr = {state == IDLE ? wr_bank : ~wr_bank, load_idx[AW-1:0]};
  assign fwd = state == IDLE && w_en && wr_ptr == '0;
  always_ff @(posedge clk) begin
    if (w_en) begin
      mem0[w_addr] <= w0;
      mem1[w_addr] <= w1;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rows_valid <= '0;
      wr_bank <= 1'b0;
      overflow <= 1'b0;
    end else if (clear) begin
      wr_ptr <= '0;
      rows_valid <= '0;
      overflow <= 1'b0;
    end else begin
      if (in_valid && wr_ptr == FULL) overflow <= 1'b1;
      wr_ptr <= swap_acc || rewind ? '0 : wr_ptr + PW'(w_en);
      rows_valid <= swap_acc ? '0 : rows_next;
      if (swap_acc) wr_bank <= ~wr_bank;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      rd_ptr <= '0;
      drain_count <= '0;
      out_col0 <= '0;
      out_col1 <= '0;
      out_last <= 1'b0;
    end else begin
      state <= state_next;
      if (swap_acc) drain_count <= rows_next;
      if (load) begin
        rd_ptr <= load_idx;
        out_col0 <= fwd ? w0 : mem0[r_addr];
        out_col1 <= fwd ? w1 : mem1[r_addr];
        out_last <= load_idx == cnt - 1'b1;
      end else if (state_next == IDLE) begin
        out_last <= 1'b0;
      end
    end
  end
endmodule
